seg_display_arbiter: RTL and testbench

Shares the Go Board's two-digit seven-segment display between two independent value sources, e.g. the debounced switch counter and a free-running timer. Sources request the display with a level request; the arbiter grants one at a time, round-robin, with a guaranteed minimum hold time and a blanking gap between owners. It forwards the owner's two BCD digits to the pair of binary-to-seven-segment converters.

---
 rtl/seg_display_arbiter.sv | 177 +++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares the two-digit seven-segment display between two
// value sources. Round-robin grant, minimum hold time, blanking gap between owners.
// Optional macro SEG_ARB_BCD_CHECK_EN: nibbles above 9 are clamped to 9 and
// flagged on o_Range_Err; without it nibbles pass straight through.
module seg_display_arbiter #(
  parameter int HOLD_CYCLES  = 25000000,
  parameter int BLANK_CYCLES = 2500000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [1:0] i_Req,
  input  logic [7:0] i_Value_0,
  input  logic [7:0] i_Value_1,
  output logic [1:0] o_Grant,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones,
  output logic       o_Blank,
  output logic       o_Range_Err
);

  localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             r_State;
  state_t             w_NextState;
  logic               r_Owner;
  logic               w_NextOwner;
  logic               r_Ptr;
  logic               w_NextPtr;
  logic [HOLD_W-1:0]  r_Hold;
  logic [HOLD_W-1:0]  w_NextHold;
  logic [BLANK_W-1:0] r_Gap;
  logic [BLANK_W-1:0] w_NextGap;

  logic [1:0]         r_Grant;
  logic [3:0]         r_Tens;
  logic [3:0]         r_Ones;
  logic               r_Blank;

  logic [7:0]         w_OwnerValue;
  logic [3:0]         w_TensIn;
  logic [3:0]         w_OnesIn;
  logic               w_Load;

  // Next-state logic: arbitration in IDLE, hold/release decisions in OWN, blank timing in GAP
  always_comb begin
    w_NextState = r_State;
    w_NextOwner = r_Owner;
    w_NextPtr   = r_Ptr;
    w_NextHold  = r_Hold;
    w_NextGap   = r_Gap;
    case (r_State)
      IDLE: begin
        if (i_Req != 2'b00) begin
          w_NextState = OWN;
          w_NextHold  = '0;
          if (i_Req == 2'b11) begin
            w_NextOwner = r_Ptr;
          end else begin
            w_NextOwner = i_Req[1];
          end
          w_NextPtr = ~w_NextOwner;
        end
      end
      OWN: begin
        if (!i_Req[r_Owner]) begin
          w_NextState = GAP;
          w_NextGap   = '0;
        end else if (r_Hold == HOLD_MAX) begin
          if (i_Req[~r_Owner]) begin
            w_NextState = GAP;
            w_NextGap   = '0;
          end
        end else begin
          w_NextHold = r_Hold + 1'b1;
        end
      end
      GAP: begin
        if (r_Gap == BLANK_MAX) begin
          w_NextState = IDLE;
        end else begin
          w_NextGap = r_Gap + 1'b1;
        end
      end
      default: begin
        w_NextState = IDLE;
      end
    endcase
  end

  // Digits are captured on every edge that leaves the arbiter owned by a source
  always_comb begin
    w_OwnerValue = w_NextOwner ? i_Value_1 : i_Value_0;
    w_Load       = (w_NextState == OWN);
  end

`ifdef SEG_ARB_BCD_CHECK_EN
  logic w_TensBad;
  logic w_OnesBad;
  logic r_RangeErr;

  // Clamp non-BCD nibbles to 9 before they reach the converters
  always_comb begin
    w_TensBad = (w_OwnerValue[7:4] > 4'd9);
    w_OnesBad = (w_OwnerValue[3:0] > 4'd9);
    w_TensIn  = w_TensBad ? 4'd9 : w_OwnerValue[7:4];
    w_OnesIn  = w_OnesBad ? 4'd9 : w_OwnerValue[3:0];
  end

  // Flag a clamped digit in the same cycle it appears on the outputs
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_RangeErr <= 1'b0;
    end else begin
      r_RangeErr <= w_Load & (w_TensBad | w_OnesBad);
    end
  end

  assign o_Range_Err = r_RangeErr;
`else
  // Nibbles pass through untouched when checking is not built in
  always_comb begin
    w_TensIn = w_OwnerValue[7:4];
    w_OnesIn = w_OwnerValue[3:0];
  end

  assign o_Range_Err = 1'b0;
`endif

  // State register with counters and round-robin pointer
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State <= IDLE;
      r_Owner <= 1'b0;
      r_Ptr   <= 1'b0;
      r_Hold  <= '0;
      r_Gap   <= '0;
    end else begin
      r_State <= w_NextState;
      r_Owner <= w_NextOwner;
      r_Ptr   <= w_NextPtr;
      r_Hold  <= w_NextHold;
      r_Gap   <= w_NextGap;
    end
  end

  // Registered outputs: grant and blank follow the next state, digits hold outside ownership
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Grant <= 2'b00;
      r_Blank <= 1'b1;
      r_Tens  <= 4'd0;
      r_Ones  <= 4'd0;
    end else begin
      r_Grant <= w_Load ? (w_NextOwner ? 2'b10 : 2'b01) : 2'b00;
      r_Blank <= ~w_Load;
      if (w_Load) begin
        r_Tens <= w_TensIn;
        r_Ones <= w_OnesIn;
      end
    end
  end

  assign o_Grant = r_Grant;
  assign o_Tens  = r_Tens;
  assign o_Ones  = r_Ones;
  assign o_Blank = r_Blank;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model. Honours SEG_ARB_BCD_CHECK_EN when defined.
module tb_seg_display_arbiter;

  localparam int HOLD  = 4;
  localparam int BLANK = 2;

  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic [1:0] i_Req = 2'b00;
  logic [7:0] i_Value_0 = 8'h00;
  logic [7:0] i_Value_1 = 8'h00;
  logic [1:0] o_Grant;
  logic [3:0] o_Tens;
  logic [3:0] o_Ones;
  logic       o_Blank;
  logic       o_Range_Err;

  int checkCount = 0;
  int errorCount = 0;

  // Behavioural model: who owns the display, how long, and how much blank time is left
  int         mOwner   = -1;
  int         mFav     = 0;
  int         mOwned   = 0;
  int         mGapLeft = 0;
  logic [3:0] mTens    = 4'd0;
  logic [3:0] mOnes    = 4'd0;
  logic       mErr     = 1'b0;
  logic [7:0] mVal;
  logic       mShow;

  logic [1:0] rrPattern [18] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
                                  2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00,
                                  2'b01, 2'b01, 2'b01, 2'b01};

  seg_display_arbiter #(
    .HOLD_CYCLES (HOLD),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Req      (i_Req),
    .i_Value_0  (i_Value_0),
    .i_Value_1  (i_Value_1),
    .o_Grant    (o_Grant),
    .o_Tens     (o_Tens),
    .o_Ones     (o_Ones),
    .o_Blank    (o_Blank),
    .o_Range_Err(o_Range_Err)
  );

  // Free-running 100 MHz-style clock
  always #5 i_Clk = ~i_Clk;

  function automatic logic [3:0] shownDigit(input logic [3:0] n);
`ifdef SEG_ARB_BCD_CHECK_EN
    return (n > 4'd9) ? 4'd9 : n;
`else
    return n;
`endif
  endfunction

  function automatic logic badDigits(input logic [7:0] v);
`ifdef SEG_ARB_BCD_CHECK_EN
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
`else
    return (v == 8'hFF) && 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    checkCount++;
    if (act !== req) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [7:0] v0, input logic [7:0] v1);
    i_Req     = req;
    i_Value_0 = v0;
    i_Value_1 = v1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic doReset();
    i_Reset = 1'b1;
    applyStimulus(2'b00, 8'h00, 8'h00);
    waitCycles(2);
    i_Reset = 1'b0;
  endtask

  // Model update on every active edge and on asynchronous reset
  initial begin
    forever begin
      @(posedge i_Clk or posedge i_Reset);
      if (i_Reset) begin
        mOwner = -1; mFav = 0; mOwned = 0; mGapLeft = 0;
        mTens = 4'd0; mOnes = 4'd0; mErr = 1'b0;
      end else begin
        mShow = 1'b0;
        mErr  = 1'b0;
        if (mOwner >= 0) begin
          if (!i_Req[mOwner] || (mOwned >= HOLD && i_Req[1-mOwner])) begin
            mOwner   = -1;
            mGapLeft = BLANK;
          end else begin
            if (mOwned < HOLD) mOwned++;
            mShow = 1'b1;
          end
        end else if (mGapLeft > 0) begin
          mGapLeft--;
        end else if (i_Req != 2'b00) begin
          mOwner = (i_Req == 2'b11) ? mFav : (i_Req[1] ? 1 : 0);
          mFav   = 1 - mOwner;
          mOwned = 1;
          mShow  = 1'b1;
        end
        if (mShow) begin
          mVal  = (mOwner == 1) ? i_Value_1 : i_Value_0;
          mTens = shownDigit(mVal[7:4]);
          mOnes = shownDigit(mVal[3:0]);
          mErr  = badDigits(mVal);
        end
      end
    end
  end

  // Compare every output against the model on each falling edge
  initial begin
    forever begin
      @(negedge i_Clk);
      checkOutput("grant", {6'b0, o_Grant},
                  {6'b0, (mOwner < 0) ? 2'b00 : ((mOwner == 0) ? 2'b01 : 2'b10)});
      checkOutput("blank", {7'b0, o_Blank}, {7'b0, (mOwner < 0)});
      checkOutput("tens", {4'b0, o_Tens}, {4'b0, mTens});
      checkOutput("ones", {4'b0, o_Ones}, {4'b0, mOnes});
      checkOutput("range_err", {7'b0, o_Range_Err}, {7'b0, mErr});
    end
  end

  // Guard against a stuck run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    waitCycles(2);
    i_Reset = 1'b0;

    waitCycles(10);
    checkOutput("idle_grant", {6'b0, o_Grant}, 8'h00);
    checkOutput("idle_blank", {7'b0, o_Blank}, 8'h01);
    checkOutput("idle_tens", {4'b0, o_Tens}, 8'h00);
    checkOutput("idle_ones", {4'b0, o_Ones}, 8'h00);

    applyStimulus(2'b01, 8'h37, 8'h00);
    waitCycles(1);
    checkOutput("single_grant", {6'b0, o_Grant}, 8'h01);
    checkOutput("single_tens", {4'b0, o_Tens}, 8'h03);
    checkOutput("single_ones", {4'b0, o_Ones}, 8'h07);
    checkOutput("single_blank", {7'b0, o_Blank}, 8'h00);
    waitCycles(20);
    checkOutput("single_hold", {6'b0, o_Grant}, 8'h01);
    applyStimulus(2'b00, 8'h37, 8'h00);
    waitCycles(5);

    doReset();
    applyStimulus(2'b11, 8'h37, 8'h42);
    for (int k = 0; k < 18; k++) begin
      waitCycles(1);
      checkOutput("rr_grant", {6'b0, o_Grant}, {6'b0, rrPattern[k]});
      if (k == 7) begin
        checkOutput("rr_tens", {4'b0, o_Tens}, 8'h04);
        checkOutput("rr_ones", {4'b0, o_Ones}, 8'h02);
      end
    end

    doReset();
    applyStimulus(2'b01, 8'h37, 8'h42);
    waitCycles(2);
    applyStimulus(2'b10, 8'h37, 8'h42);
    waitCycles(1);
    checkOutput("early_release", {6'b0, o_Grant}, 8'h00);
    waitCycles(2);
    checkOutput("early_idle", {6'b0, o_Grant}, 8'h00);
    waitCycles(1);
    checkOutput("early_next", {6'b0, o_Grant}, 8'h02);
    checkOutput("early_tens", {4'b0, o_Tens}, 8'h04);

    waitCycles(1);
    #2;
    i_Reset = 1'b1;
    #1;
    checkOutput("async_grant", {6'b0, o_Grant}, 8'h00);
    checkOutput("async_blank", {7'b0, o_Blank}, 8'h01);
    checkOutput("async_tens", {4'b0, o_Tens}, 8'h00);
    checkOutput("async_ones", {4'b0, o_Ones}, 8'h00);
    @(negedge i_Clk);
    i_Reset = 1'b0;
    applyStimulus(2'b11, 8'h37, 8'h42);
    waitCycles(1);
    checkOutput("async_restart", {6'b0, o_Grant}, 8'h01);

    doReset();
    applyStimulus(2'b01, 8'hA5, 8'h00);
    for (int k = 0; k < 3; k++) begin
      waitCycles(1);
`ifdef SEG_ARB_BCD_CHECK_EN
      checkOutput("range_tens", {4'b0, o_Tens}, 8'h09);
      checkOutput("range_flag", {7'b0, o_Range_Err}, 8'h01);
`else
      checkOutput("range_tens", {4'b0, o_Tens}, 8'h0A);
      checkOutput("range_flag", {7'b0, o_Range_Err}, 8'h00);
`endif
      checkOutput("range_ones", {4'b0, o_Ones}, 8'h05);
    end
    applyStimulus(2'b01, 8'h12, 8'h00);
    waitCycles(1);
    checkOutput("range_clear", {7'b0, o_Range_Err}, 8'h00);

    doReset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_Req = 2'($urandom_range(0, 3));
      end
      i_Value_0 = 8'($urandom);
      i_Value_1 = 8'($urandom);
      waitCycles(1);
    end

    waitCycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
